// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: echo controller between UART RX and TX.
// Received bytes are buffered in a circular FIFO and drained to the transmitter
// in immediate, threshold or line mode. Each frame uses a start/done handshake,
// followed by a programmable inter-byte gap.
// Optional saturating statistics counters are enabled by defining ECHO_STATS_EN.
module uart_echo_ctrl #(
  parameter int unsigned          DATA_BITS  = 8,
  parameter int unsigned          DEPTH      = 16,
  parameter int unsigned          GAP_CYCLES = 5,
  parameter logic [DATA_BITS-1:0] EOL_CHAR   = DATA_BITS'(8'h0D)
) (
  input  logic                   sysclk,
  input  logic                   rst_in,
  input  logic [1:0]             mode_in,
  input  logic [$clog2(DEPTH):0] thresh_in,
  input  logic                   rx_valid_in,
  input  logic [DATA_BITS-1:0]   rx_data_in,
  output logic [DATA_BITS-1:0]   tx_data_out,
  output logic                   tx_start_out,
  input  logic                   tx_done_in,
  output logic [$clog2(DEPTH):0] level_out,
  output logic                   empty_out,
  output logic                   full_out,
  output logic                   overflow_out,
  output logic                   busy_out
`ifdef ECHO_STATS_EN
  ,
  output logic [15:0]            rx_count_out,
  output logic [15:0]            tx_count_out,
  output logic [15:0]            drop_count_out
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;
  typedef enum logic [1:0] {MODE_IMM = 2'd0, MODE_THR = 2'd1, MODE_LINE = 2'd2} mode_t;

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d, mode_in_n, mode_cur;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d, eol_cnt_q, eol_cnt_d, thresh_eff;
  logic                 overflow_q, overflow_d, latch_q, latch_d, forced_q, forced_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d, head;
  logic [GW-1:0]        gap_q, gap_d;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 empty, full, drain, pop, push, drop, mode_chg, eol_in, eol_out;
`ifdef ECHO_STATS_EN
  logic [15:0]          rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

  // Next-state logic: FIFO bookkeeping, drain decision, handshake FSM, counters
  always_comb begin
    head      = mem[rd_ptr_q];
    empty     = (level_q == '0);
    full      = (level_q == LW'(DEPTH));
    mode_in_n = (mode_in == 2'd3) ? MODE_IMM : mode_t'(mode_in);
    mode_cur  = (state_q == IDLE) ? mode_in_n : mode_q;
    mode_chg  = (state_q == IDLE) && (mode_in_n != mode_q);

    if (thresh_in == '0)              thresh_eff = LW'(1);
    else if (thresh_in > LW'(DEPTH))  thresh_eff = LW'(DEPTH);
    else                              thresh_eff = thresh_in;

    case (mode_cur)
      MODE_THR:  drain = latch_q && !empty;
      MODE_LINE: drain = (eol_cnt_q != '0) || forced_q;
      default:   drain = !empty;
    endcase

    pop     = (state_q == IDLE) && drain && !empty;
    push    = rx_valid_in && (!full || pop);
    drop    = rx_valid_in && full && !pop;
    eol_in  = push && (rx_data_in == EOL_CHAR);
    eol_out = pop && (head == EOL_CHAR);

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    eol_cnt_d  = eol_cnt_q + LW'(eol_in) - LW'(eol_out);
    overflow_d = overflow_q | drop;

    mode_d   = mode_q;
    latch_d  = latch_q;
    forced_d = forced_q;
    if (mode_chg) begin
      mode_d   = mode_in_n;
      latch_d  = 1'b0;
      forced_d = 1'b0;
    end else if (level_d == '0) begin
      latch_d  = 1'b0;
      forced_d = 1'b0;
    end else begin
      if ((mode_cur == MODE_THR) && (level_d >= thresh_eff))
        latch_d = 1'b1;
      if ((mode_cur == MODE_LINE) && (level_d == LW'(DEPTH)) && (eol_cnt_d == '0))
        forced_d = 1'b1;
    end

    state_d    = state_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // a done pulse in the same cycle as our own start belongs to no frame of ours
        if (tx_done_in && !tx_start_q) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GW'(GAP_CYCLES);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) state_d = IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase

`ifdef ECHO_STATS_EN
    rx_cnt_d   = (push && (rx_cnt_q != '1))   ? rx_cnt_q + 16'd1   : rx_cnt_q;
    tx_cnt_d   = (pop  && (tx_cnt_q != '1))   ? tx_cnt_q + 16'd1   : tx_cnt_q;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
`endif
  end

  // State registers; async reset also abandons any frame in flight
  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      mode_q     <= MODE_IMM;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      eol_cnt_q  <= '0;
      overflow_q <= 1'b0;
      latch_q    <= 1'b0;
      forced_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      gap_q      <= '0;
`ifdef ECHO_STATS_EN
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      eol_cnt_q  <= eol_cnt_d;
      overflow_q <= overflow_d;
      latch_q    <= latch_d;
      forced_q   <= forced_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      gap_q      <= gap_d;
`ifdef ECHO_STATS_EN
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers restart
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr_q] <= rx_data_in;
  end

  assign tx_data_out  = tx_data_q;
  assign tx_start_out = tx_start_q;
  assign level_out    = level_q;
  assign empty_out    = empty;
  assign full_out     = full;
  assign overflow_out = overflow_q;
  assign busy_out     = (state_q != IDLE);
`ifdef ECHO_STATS_EN
  assign rx_count_out   = rx_cnt_q;
  assign tx_count_out   = tx_cnt_q;
  assign drop_count_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: self-checking bench for uart_echo_ctrl (default parameters).
// A queue-based reference model predicts the outputs after every clock edge.
module tb_uart_echo_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 5;
  localparam logic [7:0]  EOL   = 8'h0D;

  logic       sysclk = 1'b0;
  logic       rst_in = 1'b1;
  logic [1:0] mode_in = 2'd0;
  logic [4:0] thresh_in = 5'd1;
  logic       rx_valid_in = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic       tx_done_in = 1'b0;
  logic [7:0] tx_data_out;
  logic       tx_start_out;
  logic [4:0] level_out;
  logic       empty_out, full_out, overflow_out, busy_out;
`ifdef ECHO_STATS_EN
  logic [15:0] rx_count_out, tx_count_out, drop_count_out;
`endif

  always #5 sysclk = ~sysclk;

  uart_echo_ctrl #(.DATA_BITS(8), .DEPTH(16), .GAP_CYCLES(5), .EOL_CHAR(8'h0D)) dut (
    .sysclk(sysclk), .rst_in(rst_in), .mode_in(mode_in), .thresh_in(thresh_in),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in),
    .tx_data_out(tx_data_out), .tx_start_out(tx_start_out), .tx_done_in(tx_done_in),
    .level_out(level_out), .empty_out(empty_out), .full_out(full_out),
    .overflow_out(overflow_out), .busy_out(busy_out)
`ifdef ECHO_STATS_EN
    , .rx_count_out(rx_count_out), .tx_count_out(tx_count_out), .drop_count_out(drop_count_out)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned edge_no = 0;
  logic [7:0]  got[$];
  logic [7:0]  wq[$];
  logic [7:0]  e[$];

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          m_ovf, m_out, m_start, m_latch, m_forced;
  int unsigned m_ready;
  logic [1:0]  m_mode;
  logic [7:0]  m_data;
  int unsigned m_rx, m_tx, m_drop;

  function automatic int m_eols();
    int n = 0;
    foreach (mq[i]) if (mq[i] == EOL) n++;
    return n;
  endfunction

  function automatic logic [1:0] norm(input logic [1:0] m);
    return (m == 2'd3) ? 2'd0 : m;
  endfunction

  function automatic int m_thr();
    if (thresh_in == 0) return 1;
    if (thresh_in > DEPTH) return DEPTH;
    return int'(thresh_in);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_out = 0; m_start = 0; m_latch = 0; m_forced = 0;
    m_ready = 0; m_mode = 2'd0; m_data = 8'h00;
    m_rx = 0; m_tx = 0; m_drop = 0;
  endtask

  // One clock edge: decide pop from pre-edge contents, then retire done, then accept the byte.
  task automatic model_edge();
    bit idle_b, drain, pop;
    logic [1:0] me;
    idle_b = !m_out && (edge_no >= m_ready);
    me = idle_b ? norm(mode_in) : m_mode;
    drain = 0;
    if (idle_b) begin
      case (me)
        2'd1:    drain = m_latch && (mq.size() > 0);
        2'd2:    drain = (m_eols() > 0) || m_forced;
        default: drain = (mq.size() > 0);
      endcase
    end
    pop = drain && (mq.size() > 0);
    if (m_out && !m_start && tx_done_in) begin
      m_out = 0;
      m_ready = edge_no + GAP + 1;
    end
    m_start = 0;
    if (pop) begin
      m_data = mq.pop_front();
      m_start = 1; m_out = 1; m_tx++;
    end
    if (rx_valid_in) begin
      if (mq.size() < DEPTH) begin mq.push_back(rx_data_in); m_rx++; end
      else begin m_ovf = 1; m_drop++; end
    end
    if (idle_b && norm(mode_in) != m_mode) begin
      m_mode = norm(mode_in); m_latch = 0; m_forced = 0;
    end else if (mq.size() == 0) begin
      m_latch = 0; m_forced = 0;
    end else begin
      if (me == 2'd1 && mq.size() >= m_thr()) m_latch = 1;
      if (me == 2'd2 && mq.size() == DEPTH && m_eols() == 0) m_forced = 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_got(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), got[i], exp[i]);
    got.delete();
  endtask

  // Advance one edge, step the model, sample #1 later and compare against it.
  task automatic cyc();
    logic [18:0] act, exp;
    bit busy_exp;
    @(posedge sysclk);
    edge_no++;
    if (!rst_in) model_edge();
    #1;
    if (!rst_in) begin
      busy_exp = m_out || (edge_no + 1 < m_ready);
      exp = {5'(mq.size()), mq.size() == 0, mq.size() == DEPTH, m_ovf, m_start, busy_exp, m_data};
      act = {level_out, empty_out, full_out, overflow_out, tx_start_out, busy_out, tx_data_out};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model_cycle edge %0d: got lvl=%0d e=%0b f=%0b ovf=%0b st=%0b busy=%0b data=%02h, expected lvl=%0d e=%0b f=%0b ovf=%0b st=%0b busy=%0b data=%02h",
                 edge_no, act[18:14], act[13], act[12], act[11], act[10], act[9], act[7:0],
                 exp[18:14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[7:0]);
      end
`ifdef ECHO_STATS_EN
      chk("model_stats", {rx_count_out, tx_count_out}, {16'(m_rx), 16'(m_tx)});
      chk("model_drops", drop_count_out, 16'(m_drop));
`endif
    end
  endtask

  // Run ncyc cycles: write one byte from wq every 'period' cycles and answer each
  // start with a done pulse two cycles later, collecting transmitted bytes.
  task automatic run(input int ncyc, input int period);
    int age = -1;
    for (int c = 0; c < ncyc; c++) begin
      rx_valid_in = (wq.size() > 0) && (c % period == 0);
      if (rx_valid_in) rx_data_in = wq.pop_front();
      tx_done_in = (age == 2);
      cyc();
      if (tx_done_in) age = -1;
      else if (age >= 0) age++;
      if (tx_start_out) begin got.push_back(tx_data_out); age = 0; end
    end
    rx_valid_in = 1'b0;
    tx_done_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy_out; i++) cyc();
    chk("wait_idle", busy_out, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, level_out, 0);
    chk({tag, "_flags"}, {empty_out, full_out, overflow_out, tx_start_out, busy_out}, 5'b10000);
    chk({tag, "_data"}, tx_data_out, 8'h00);
`ifdef ECHO_STATS_EN
    chk({tag, "_stats"}, {rx_count_out, tx_count_out, drop_count_out}, 48'd0);
`endif
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [4:0] lvl;
    bit         full;
    bit         ovf;
    bit         start;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int n;
    // overflow / full-with-pop vectors
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(8'h60 + i), 5'(i + 1), i == 15, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'h55, 5'd16, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 8'h77, 5'd16, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b1, 1'b0};

    model_reset();
    @(posedge sysclk); @(posedge sysclk); #1;
    chk_reset_vals("reset");
    rst_in = 1'b0;
    model_reset();

    // mode 0 latency and gap
    rx_valid_in = 1'b1; rx_data_in = 8'hA5; cyc(); rx_valid_in = 1'b0;
    chk("lat_no_start_k1", tx_start_out, 1'b0);
    chk("lat_level_k1", level_out, 1);
    cyc();
    chk("lat_start_k2", tx_start_out, 1'b1);
    chk("lat_data", tx_data_out, 8'hA5);
    chk("lat_busy", busy_out, 1'b1);
    rx_valid_in = 1'b1; rx_data_in = 8'h3C; cyc(); rx_valid_in = 1'b0;
    chk("start_one_cycle", tx_start_out, 1'b0);
    cyc();
    tx_done_in = 1'b1; cyc(); tx_done_in = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); n++;
      if (tx_start_out) break;
    end
    chk("gap_edges_to_start", n, GAP + 1);
    chk("gap_data", tx_data_out, 8'h3C);
    tx_done_in = 1'b1; cyc(); tx_done_in = 1'b0;
    cyc(); cyc(); cyc();
    chk("done_with_start_ignored", busy_out, 1'b1);
    tx_done_in = 1'b1; cyc(); tx_done_in = 1'b0;
    chk("gap_busy", busy_out, 1'b1);
    wait_idle();

    // threshold mode
    mode_in = 2'd1; thresh_in = 5'd4;
    wq = {8'h11, 8'h22, 8'h33};
    run(15, 1);
    chk("thr_below_level", level_out, 3);
    e.delete(); chk_got("thr_below", e);
    wq = {8'h44};
    run(60, 1);
    e = {8'h11, 8'h22, 8'h33, 8'h44}; chk_got("thr_drain", e);
    chk("thr_empty", empty_out, 1'b1);
    wq = {8'h55};
    run(15, 1);
    chk("thr_latch_cleared_level", level_out, 1);
    e.delete(); chk_got("thr_latch_cleared", e);
    mode_in = 2'd3;
    run(30, 1);
    e = {8'h55}; chk_got("mode3_immediate", e);
    mode_in = 2'd1; thresh_in = 5'd0;
    wq = {8'h66};
    run(30, 1);
    e = {8'h66}; chk_got("thr_zero", e);

    // line mode
    mode_in = 2'd2;
    wq = {8'h61, 8'h62, EOL, 8'h63};
    run(60, 1);
    e = {8'h61, 8'h62, EOL}; chk_got("line_first", e);
    chk("line_held_level", level_out, 1);
    wq = {EOL};
    run(40, 1);
    e = {8'h63, EOL}; chk_got("line_second", e);
    e.delete();
    for (int i = 0; i < 16; i++) begin wq.push_back(8'(8'h40 + i)); e.push_back(8'(8'h40 + i)); end
    run(250, 1);
    chk_got("line_forced", e);
    chk("line_forced_empty", empty_out, 1'b1);
    chk("line_no_overflow", overflow_out, 1'b0);

    // overflow and full push+pop, table driven
    wait_idle();
    mode_in = 2'd1; thresh_in = 5'd16;
    for (int i = 0; i < 19; i++) begin
      rx_valid_in = tbl[i].v; rx_data_in = tbl[i].d;
      cyc();
      chk($sformatf("tbl%0d_level", i), level_out, tbl[i].lvl);
      chk($sformatf("tbl%0d_flags", i), {full_out, overflow_out, tx_start_out},
          {tbl[i].full, tbl[i].ovf, tbl[i].start});
    end
    rx_valid_in = 1'b0;
    chk("tbl_tx_data_held", tx_data_out, 8'h60);

    // asynchronous reset mid-frame
    chk("pre_reset_busy", busy_out, 1'b1);
    #2; rst_in = 1'b1; #1;
    chk_reset_vals("async_reset");
    @(posedge sysclk); @(posedge sysclk); #1;
    rst_in = 1'b0;
    model_reset();
    tx_done_in = 1'b1; cyc(); tx_done_in = 1'b0;
    chk("late_done_busy", busy_out, 1'b0);
    chk("late_done_start", tx_start_out, 1'b0);

    // pointer wrap in mode 0
    mode_in = 2'd0;
    e.delete();
    for (int i = 0; i < 40; i++) begin wq.push_back(8'(i)); e.push_back(8'(i)); end
    run(450, 8);
    chk_got("wrap", e);
    chk("wrap_no_overflow", overflow_out, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        mode_in = 2'($urandom_range(0, 3));
        thresh_in = 5'($urandom_range(0, 31));
      end
      if (c == 1500) begin
        #2; rst_in = 1'b1; #1;
        chk("rand_async_reset_level", level_out, 0);
        @(posedge sysclk); #1;
        rst_in = 1'b0;
        model_reset();
      end
      rx_valid_in = ($urandom_range(0, 99) < 45);
      rx_data_in = ($urandom_range(0, 5) == 0) ? EOL : 8'($urandom);
      tx_done_in = ($urandom_range(0, 99) < 30);
      cyc();
    end
    rx_valid_in = 1'b0;
    tx_done_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
- Parametrised echo controller between the UART RX and TX sides.
- Buffers received bytes in an internal single-clock circular FIFO.
- Drains the FIFO to the transmitter under one of three selectable modes: immediate, threshold or line.
- Replaces the fixed "read only when full, fixed delay" echo loop with a proper start/done handshake and a programmable inter-byte gap.

Parameters:
- DATA_BITS, 8, byte width.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- GAP_CYCLES, 5, idle sysclk cycles after tx_done_in before the next start; 0 allowed.
- EOL_CHAR, 8'h0D, line-mode terminator; compared over DATA_BITS.

Ports:
- sysclk, in, 1, system clock; all logic on posedge.
- rst_in, in, 1, reset; asynchronous, active-high.
- mode_in, in, 2, drain mode: 0 immediate, 1 threshold, 2 line, 3 behaves as 0.
- thresh_in, in, $clog2(DEPTH)+1, threshold-mode level; 0 treated as 1; values > DEPTH treated as DEPTH.
- rx_valid_in, in, 1, one-cycle pulse: rx_data_in valid.
- rx_data_in, in, DATA_BITS, received byte.
- tx_data_out, out, DATA_BITS, byte for transmitter; stable from tx_start_out until tx_done_in.
- tx_start_out, out, 1, one-cycle start pulse to transmitter.
- tx_done_in, in, 1, one-cycle pulse when the transmitter frame completes.
- level_out, out, $clog2(DEPTH)+1, FIFO occupancy 0..DEPTH.
- empty_out, out, 1, level_out == 0.
- full_out, out, 1, level_out == DEPTH.
- overflow_out, out, 1, sticky: a byte was dropped.
- busy_out, out, 1, FSM not in IDLE.

Behaviour:
- Reset (async, any time):
  - Outputs: level 0, empty_out 1, full_out 0, overflow_out 0, tx_start_out 0, tx_data_out 0, busy_out 0.
  - Internal: FSM to IDLE, drain latch 0, EOL count 0, pointers 0.
  - A transmitter frame already in flight is abandoned.
- FIFO:
  - Write on rx_valid_in. Read pointer wraps modulo DEPTH.
  - Full with no pop in the same cycle: byte dropped, overflow_out set, held until reset.
  - Full with a pop in the same cycle: write accepted, level unchanged.
  - Empty: pop never issued.
- EOL count: +1 on an accepted write of EOL_CHAR, -1 on a pop of EOL_CHAR; simultaneous +1/-1 cancel.
- Drain condition, evaluated in IDLE:
  - Mode 0: !empty.
  - Mode 1: drain latch set when level >= effective thresh_in; cleared when the FIFO becomes empty; drain = latch && !empty.
  - Mode 2: drain = (EOL count > 0) || forced.
    - forced is set when full with EOL count 0 (deadlock breaker) and cleared on empty.
- FSM states: IDLE, WAIT_DONE, GAP.
  - IDLE, drain true at edge E: pop head into tx_data_out; tx_start_out high in cycle E+1 only; go to WAIT_DONE.
  - WAIT_DONE, on tx_done_in: if GAP_CYCLES == 0 go to IDLE, else load the counter and go to GAP.
  - GAP: down-count GAP_CYCLES cycles, then IDLE.
- Latency: rx_valid_in at edge k with an empty FIFO in mode 0 and the FSM in IDLE gives tx_start_out high in cycle k+2.
- tx_done_in outside WAIT_DONE is ignored. tx_done_in coincident with tx_start_out is ignored.
- mode_in is sampled only in IDLE. A mode change clears the drain latch and forced.

Optional Feature:
- Macro: ECHO_STATS_EN.
- Defined: adds three 16-bit outputs, each saturating at 16'hFFFF and reset to 0:
  - rx_count_out: accepted writes.
  - tx_count_out: tx_start_out pulses.
  - drop_count_out: dropped bytes.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Mode 0, single rx_valid_in with 8'hA5 -> tx_start_out in cycle k+2, tx_data_out == 8'hA5. After tx_done_in, no new start for 5 cycles (GAP_CYCLES=5).
- Mode 1, thresh_in 4, write 3 bytes -> no start. Write a 4th -> 4 bytes sent in order. Drain continues to empty even while level < 4; latch cleared.
- Mode 2, write "ab", then 8'h0D, then "c" -> a, b, 0D sent; c held until the next EOL. Separately, fill 16 bytes with no EOL -> forced drain of all 16.
- Overflow: fill 16 with no drain (mode 1, thresh 16, tx_done_in withheld), write 8'h77 -> dropped, overflow_out 1, level 16. Push and pop in the same cycle while full -> write accepted, level stays 16.
- Wrap: 40 bytes 0..39 streamed in mode 0 with a prompt tx_done_in -> output sequence 0..39 exact across pointer wrap.
- Reset mid-frame: assert rst_in in WAIT_DONE -> all outputs at reset values immediately, without waiting for a clock. A late tx_done_in after release -> ignored. (ECHO_STATS_EN: counters 0.)
